// File: rtl/wm8731_pkg.sv
// Shared WM8731 audio-interface definitions: slot FSM states and default slot geometry.
package wm8731_pkg;

  localparam int SLOT_W_DEF = 32;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = $clog2(SLOT_W_DEF);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_PAD,
    ST_DATA,
    ST_HOLD
  } slot_state_e;

endpackage

// File: rtl/adc_slot_tx.sv
// Serialises one right-justified sample per right-channel slot onto AUD_ADCDAT, MSB first.
// Optional feature: define ADC_SLOT_TX_SIGNEXT_EN to sign-extend the sample into the pad bits.
module adc_slot_tx
  import wm8731_pkg::*;
#(
  parameter int SLOT_W = SLOT_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     AUD_BCLK,
  input  logic                     AUD_ADCLRCK,
  input  logic signed [DATA_W-1:0] iSample,
  input  logic                     iValid,
  output logic                     oReady,
  output logic                     oAUD_ADCDAT,
  output logic                     oUnderrun,
  output logic                     oDone
);

  localparam int             K_W    = $clog2(SLOT_W);
  localparam logic [K_W-1:0] K_LAST = K_W'(SLOT_W - 1);
  localparam logic [K_W-1:0] K_PAD  = K_W'(SLOT_W - DATA_W);
  localparam logic [K_W-1:0] K_ONE  = K_W'(1);

  slot_state_e       state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [SLOT_W-1:0] sh_q, sh_d;
  logic              dat_q, dat_d;
  logic              und_q, und_d;
  logic              done_q, done_d;

  logic [SLOT_W-1:0] load_word;
  logic [K_W-1:0]    k_nxt;

  // Whole slot word is built at LOAD; its MSB leaves on the same edge, so the rest is stored pre-shifted.
`ifdef ADC_SLOT_TX_SIGNEXT_EN
  assign load_word = iValid ? SLOT_W'(signed'(iSample)) : '0;
`else
  assign load_word = iValid ? SLOT_W'($unsigned(iSample)) : '0;
`endif

  assign k_nxt  = k_q + K_ONE;
  assign oReady = (state_q == ST_LOAD) && !AUD_ADCLRCK;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case can infer a latch.
    state_d = state_q;
    k_d     = k_q;
    sh_d    = sh_q;
    dat_d   = dat_q;
    und_d   = und_q;
    done_d  = done_q;
    unique case (state_q)
      ST_LOAD: begin
        und_d   = !iValid;
        dat_d   = load_word[SLOT_W-1];
        sh_d    = load_word << 1;
        k_d     = K_ONE;
        state_d = (K_ONE < K_PAD) ? ST_PAD : ST_DATA;
      end
      ST_PAD, ST_DATA: begin
        dat_d = sh_q[SLOT_W-1];
        sh_d  = sh_q << 1;
        if (k_q == K_LAST) begin
          state_d = ST_HOLD;
        end else begin
          k_d     = k_nxt;
          state_d = (k_nxt < K_PAD) ? ST_PAD : ST_DATA;
        end
      end
      ST_HOLD: begin
        dat_d  = 1'b0;
        done_d = 1'b1;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // LRCK high is the reset: the left slot is all zeros and a short frame aborts cleanly.
  always_ff @(posedge AUD_BCLK or posedge AUD_ADCLRCK) begin
    if (AUD_ADCLRCK) begin
      state_q <= ST_LOAD;
      k_q     <= '0;
      sh_q    <= '0;
      dat_q   <= 1'b0;
      und_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
      state_q <= state_d;
      k_q     <= k_d;
      sh_q    <= sh_d;
      dat_q   <= dat_d;
      und_q   <= und_d;
      done_q  <= done_d;
    end
  end

  assign oAUD_ADCDAT = dat_q;
  assign oUnderrun   = und_q;
  assign oDone       = done_q;

endmodule

// File: doc/adc_slot_tx.md
ADC_SLOT_TX -- requirements
Module: adc_slot_tx

Interface
REQ-001 Parameter SLOT_W, default 32: BCLK periods per half-frame slot.
REQ-002 Parameter DATA_W, default 16: sample width, right-justified in slot; DATA_W <= SLOT_W.
REQ-003 AUD_BCLK  input  1  clock; all flops posedge.
REQ-004 AUD_ADCLRCK  input  1  reset, asynchronous, active-high; block runs only while low (right-channel slot).
REQ-005 iSample  input  DATA_W  signed sample offered for the coming slot.
REQ-006 iValid  input  1  iSample valid.
REQ-007 oReady  output  1  block accepts iSample this cycle.
REQ-008 oAUD_ADCDAT  output  1  serial data, MSB first, codec-ADC-compatible (feeds adcRead-style receiver).
REQ-009 oUnderrun  output  1  no sample at load; slot transmits zeros.
REQ-010 oDone  output  1  all SLOT_W bits sent.

Function
REQ-011 FSM states: LOAD, PAD, DATA, HOLD; 5-bit (clog2 SLOT_W) bit counter k, cleared at LOAD.
REQ-012 Cycle 0 = first posedge AUD_BCLK after AUD_ADCLRCK falls; state LOAD, oReady=1 combinationally in LOAD only.
REQ-013 Handshake: transfer iff iValid && oReady at cycle 0; iSample latched into shift register; exactly one transfer per slot.
REQ-014 iValid low at cycle 0: shift register loads 0, oUnderrun set at that posedge, held until reset.
REQ-015 Bit 31-k of the slot word is driven on oAUD_ADCDAT, registered, from posedge k to posedge k+1, k = 0..SLOT_W-1.
REQ-016 Slot word bits SLOT_W-1..DATA_W = pad (state PAD, SLOT_W-DATA_W cycles); bits DATA_W-1..0 = sample MSB first (state DATA, DATA_W cycles).
REQ-017 After bit 0 (posedge SLOT_W-1 sent): state HOLD, oAUD_ADCDAT=0, oDone=1 from posedge SLOT_W until reset; extra BCLKs ignored, counter saturates.
REQ-018 AUD_ADCLRCK rising mid-slot (short frame): immediate abort, all state to reset values; no partial-slot flag survives.
REQ-019 iValid/iSample ignored outside LOAD; oReady never high outside LOAD.

Reset
REQ-020 While AUD_ADCLRCK high: state LOAD-pending (held), k=0, shift register 0, oAUD_ADCDAT=0, oReady=0, oUnderrun=0, oDone=0.
REQ-021 Left slot (LRCK high) therefore reads all zeros at the receiver; this is required behaviour.
REQ-022 Reset release asynchronous to AUD_BCLK falls on negedge-aligned LRCK from codec master; no extra synchronizer.

Configuration
REQ-023 Macro ADC_SLOT_TX_SIGNEXT_EN defined: pad bits = sample bit DATA_W-1 (sign extension); underrun pads 0.
REQ-024 Macro undefined: pad bits = 0.

Structure
REQ-025 Shared package wm8731_pkg: state enum, SLOT_W/DATA_W defaults, clog2 counter width constant.
REQ-026 No sub-module; single FSM + shift register + counter.

Verification
REQ-027 LRCK low, iValid=1, iSample=16'h8001, 32 BCLK -> oAUD_ADCDAT bits 0x0000_8001 (macro off) / 0xFFFF_8001 (macro on); oDone=1 at posedge 32.
REQ-028 iValid=0 at cycle 0, iValid=1 from cycle 1 with 16'h1234 -> 32 zero bits, oUnderrun=1 from posedge 0, oReady=0 after cycle 0.
REQ-029 LRCK rises after posedge 20 -> oAUD_ADCDAT, oDone, oUnderrun = 0 immediately; next slot with 16'h00FF -> 0x0000_00FF.
REQ-030 Loop into receiver model, 3 frames, right samples 16'h7FFF, 16'h0000, 16'hFFFF -> receiver right output matches each, left output 0.
REQ-031 40 BCLK in one slot with 16'hAAAA -> bits 0x0000_AAAA then 8 zeros, oDone stays 1, oReady stays 0.
